// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
//   Sequencing controller for the MULT/MULTU execution path. One N x N array
//   multiplier is time-shared across the K x K operand slices of a W x W
//   multiply (K = W/N). Shifted partial products are accumulated into a
//   2W-bit register, and the result is published as HI/LO.
//
//   Optional feature macro: MULT_SIGNED_EN
//     defined   : signed_i=1 performs a two's-complement MULT. The operands
//                 are multiplied as magnitudes and the product is negated at
//                 the end.
//     undefined : signed_i is ignored and every operation is MULTU. The
//                 magnitude and negation logic is not built. The ports and the
//                 latency are the same in both builds.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   start_i   in   request a multiply (sampled only in IDLE)
//   signed_i  in   1 = MULT, 0 = MULTU (sampled with start_i)
//   flush_i   in   abort any operation in progress; beats start_i in IDLE
//   a_i, b_i  in   W-bit operands (sampled with start_i)
//   busy_o    out  high while an operation is in flight
//   done_o    out  one-cycle pulse; hi_o/lo_o update on the same cycle
//   hi_o,lo_o out  result halves; hold their value between operations
module mult_seq_ctrl #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         signed_i,
  input  logic         flush_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  localparam int K  = W / N;
  localparam int KK = K * K;
  localparam int CW = (KK > 1) ? $clog2(KK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_a, r_b;
  logic [2*W-1:0]  r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_busy, r_done;
  logic [W-1:0]    r_hi, r_lo;

  logic            w_accept;
  logic            w_last;
  logic            w_busy_nxt, w_done_nxt;
  logic [W-1:0]    w_a_ld, w_b_ld;
  logic [N-1:0]    w_sa, w_sb;
  logic [2*N-1:0]  w_prod;
  logic [2*W-1:0]  w_pp;
  logic [2*W-1:0]  w_res;
  int              w_i, w_j;

  assign w_accept = (r_state == S_IDLE) && start_i && !flush_i;
  assign w_last   = (r_cnt == CW'(KK - 1));

  // ---------------- operand conditioning ----------------
`ifdef MULT_SIGNED_EN
  logic r_neg;
  logic w_neg_ld;
  // The magnitude of the most negative value is 2^(W-1). It fits exactly
  // when held as an unsigned W-bit value, so plain negation is enough.
  assign w_a_ld   = (signed_i && a_i[W-1]) ? (~a_i + W'(1)) : a_i;
  assign w_b_ld   = (signed_i && b_i[W-1]) ? (~b_i + W'(1)) : b_i;
  assign w_neg_ld = signed_i & (a_i[W-1] ^ b_i[W-1]);
  assign w_res    = r_neg ? (~r_acc + (2*W)'(1)) : r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_neg <= 1'b0;
    else if (w_accept) r_neg <= w_neg_ld;
  end
`else
  logic w_unused_signed;
  assign w_unused_signed = signed_i;
  assign w_a_ld = a_i;
  assign w_b_ld = b_i;
  assign w_res  = r_acc;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
      S_CALC:  if (flush_i) w_state_nxt = S_IDLE;
               else if (w_last) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (next values of registered outputs) ----------------
  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (r_state == S_FIN) && !flush_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_done_nxt) {r_hi, r_lo} <= w_res;
    end
  end

  // ---------------- slice mux, shared N x N multiplier, shift ----------------
  always_comb begin
    w_i = int'(r_cnt) % K;
    w_j = int'(r_cnt) / K;
  end

  assign w_sa   = r_a[N*w_i +: N];
  assign w_sb   = r_b[N*w_j +: N];
  assign w_prod = {{N{1'b0}}, w_sa} * {{N{1'b0}}, w_sb};
  assign w_pp   = {{(2*W-2*N){1'b0}}, w_prod} << (N * (w_i + w_j));

  // ---------------- accumulator / slice counter ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= w_a_ld;
      r_b   <= w_b_ld;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == S_CALC && !flush_i) begin
      r_acc <= r_acc + w_pp;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed testbench for mult_seq_ctrl (W=32, N=8 -> 17-cycle latency).
// Inputs are driven and outputs sampled on the falling edge of the clock.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, flush_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  mult_seq_ctrl #(.W(32), .N(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .flush_i(flush_i), .a_i(a_i), .b_i(b_i), .busy_o(busy_o),
    .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Call at a negedge. Start is driven, then the task waits for done.
  // lat counts falling edges after the accept edge (m = 0 is the first one).
  // The task returns at the negedge where done_o is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output int bcnt);
    start_i = 1'b1; a_i = a; b_i = b; signed_i = s;
    @(negedge clk);
    start_i = 1'b0; a_i = 32'h0; b_i = 32'h0;
    lat = 0; bcnt = 0;
    while (!done_o && lat < 40) begin
      if (busy_o) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 0; signed_i = 0; flush_i = 0; a_i = 0; b_i = 0;
    repeat (2) @(negedge clk);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done_o); end
    total++; if (hi_o !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi_o); end
    total++; if (lo_o !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned_small();
    int lat, bc;
    run_op(32'd3, 32'd5, 1'b0, lat, bc);
    total++; if (lat !== 17) begin bad++; $display("FAIL u3x5_latency got=%0d exp=17", lat); end
    total++; if (bc !== 17) begin bad++; $display("FAIL u3x5_busy_cycles got=%0d exp=17", bc); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL u3x5_busy_at_done got=%0b exp=0", busy_o); end
    total++; if (hi_o !== 32'h0) begin bad++; $display("FAIL u3x5_hi got=%h exp=00000000", hi_o); end
    total++; if (lo_o !== 32'hF) begin bad++; $display("FAIL u3x5_lo got=%h exp=0000000f", lo_o); end
    @(negedge clk);
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL u3x5_done_pulse got=%0b exp=0", done_o); end
  endtask

  task automatic test_unsigned_max();
    int lat, bc;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bc);
    total++; if (lat !== 17) begin bad++; $display("FAIL umax_latency got=%0d exp=17", lat); end
    total++; if (hi_o !== 32'hFFFFFFFE) begin bad++; $display("FAIL umax_hi got=%h exp=fffffffe", hi_o); end
    total++; if (lo_o !== 32'h00000001) begin bad++; $display("FAIL umax_lo got=%h exp=00000001", lo_o); end
    @(negedge clk);
  endtask

  task automatic test_signed();
    int lat, bc;
    logic [31:0] exp_hi;
`ifdef MULT_SIGNED_EN
    exp_hi = 32'hFFFFFFFF;
`else
    exp_hi = 32'h00000002;
`endif
    run_op(32'hFFFFFFFE, 32'd3, 1'b1, lat, bc);
    total++; if (hi_o !== exp_hi) begin bad++; $display("FAIL sneg2x3_hi got=%h exp=%h", hi_o, exp_hi); end
    total++; if (lo_o !== 32'hFFFFFFFA) begin bad++; $display("FAIL sneg2x3_lo got=%h exp=fffffffa", lo_o); end
    @(negedge clk);
    run_op(32'h80000000, 32'h80000000, 1'b1, lat, bc);
    total++; if (hi_o !== 32'h40000000) begin bad++; $display("FAIL smin_hi got=%h exp=40000000", hi_o); end
    total++; if (lo_o !== 32'h0) begin bad++; $display("FAIL smin_lo got=%h exp=00000000", lo_o); end
    @(negedge clk);
  endtask

  // The second start is driven at the negedge where done is seen, so the
  // accept happens on the edge where done falls.
  task automatic test_back_to_back();
    int lat, bc;
    run_op(32'd10, 32'd20, 1'b0, lat, bc);
    total++; if (lo_o !== 32'd200) begin bad++; $display("FAIL b2b_first_lo got=%h exp=000000c8", lo_o); end
    run_op(32'h00010000, 32'h00010000, 1'b0, lat, bc);
    total++; if (lat !== 17) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=17", lat); end
    total++; if (hi_o !== 32'h1 || lo_o !== 32'h0) begin
      bad++; $display("FAIL b2b_second_result got=%h_%h exp=00000001_00000000", hi_o, lo_o);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    int lat, bc, seen;
    run_op(32'd3, 32'd5, 1'b0, lat, bc);
    @(negedge clk);
    start_i = 1'b1; a_i = 32'd7; b_i = 32'd9; signed_i = 1'b0;
    @(negedge clk);                        // m=0
    start_i = 1'b0;
    repeat (4) @(negedge clk);             // m=4
    flush_i = 1'b1;                        // sampled at accept edge + 5
    @(negedge clk);                        // m=5
    flush_i = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL flush_busy got=%0b exp=0", busy_o); end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (done_o) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
    total++; if (lo_o !== 32'hF || hi_o !== 32'h0) begin
      bad++; $display("FAIL flush_hold got=%h_%h exp=00000000_0000000f", hi_o, lo_o);
    end
    run_op(32'd7, 32'd9, 1'b0, lat, bc);
    total++; if (lo_o !== 32'h3F) begin bad++; $display("FAIL flush_restart_lo got=%h exp=0000003f", lo_o); end
    @(negedge clk);
    // flush and start together in IDLE: nothing starts
    start_i = 1'b1; flush_i = 1'b1; a_i = 32'd2; b_i = 32'd2;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL flush_start_idle_busy got=%0b exp=0", busy_o); end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (done_o) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_start_idle_done got=%0d exp=0", seen); end
  endtask

  task automatic test_start_while_busy();
    int lat;
    start_i = 1'b1; a_i = 32'h1234; b_i = 32'h10; signed_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    start_i = 1'b1; a_i = 32'hFFFF; b_i = 32'hFFFF;
    @(negedge clk);
    start_i = 1'b0; a_i = 32'h0; b_i = 32'h0;
    lat = 0;
    while (!done_o && lat < 40) begin @(negedge clk); lat++; end
    total++; if (lat >= 40) begin bad++; $display("FAIL busy_start_timeout got=%0d exp<40", lat); end
    total++; if (hi_o !== 32'h0 || lo_o !== 32'h12340) begin
      bad++; $display("FAIL busy_start_result got=%h_%h exp=00000000_00012340", hi_o, lo_o);
    end
    @(negedge clk);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      if (done_o || busy_o) lat++;
      @(negedge clk);
    end
    total++; if (lat !== 0) begin bad++; $display("FAIL busy_start_no_queue got=%0d exp=0", lat); end
  endtask

  task automatic test_async_reset();
    start_i = 1'b1; a_i = 32'd100; b_i = 32'd100; signed_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL arst_busy got=%0b exp=0", busy_o); end
    total++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      bad++; $display("FAIL arst_hilo got=%h_%h exp=0_0", hi_o, lo_o);
    end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL arst_done got=%0b exp=0", done_o); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned_small();
    test_unsigned_max();
    test_signed();
    test_back_to_back();
    test_flush();
    test_start_while_busy();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
